// File: rtl/i2c_instr_loader_if.sv
// Pin-level I2C lines and the instruction-memory write port of i2c_instr_loader.
// The slave modport is the loader's view; the master modport is the board/bench view.
interface i2c_instr_loader_if #(
  parameter int ADDR_W = 8
);
  logic              scl_i;
  logic              sda_i;
  logic              sda_oe;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport slave (
    input  scl_i, sda_i,
    output sda_oe, imem_we, imem_addr, imem_wdata
  );

  modport master (
    output scl_i, sda_i,
    input  sda_oe, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/i2c_instr_loader.sv
// I2C write-only target that packs little-endian bytes into 32-bit words for instruction memory.
// Optional I2C_LOADER_OPCODE_CHECK_EN rejects words whose opcode is not a supported RV32I major opcode.
module i2c_instr_loader #(
  parameter logic [6:0] DEV_ADDR = 7'h42,
  parameter int         ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  i2c_instr_loader_if.slave bus,
  output logic              busy,
  output logic              load_done,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    IGNORE
  } state_t;

  state_t state, state_nxt;

  logic [1:0]        scl_sync, sda_sync;
  logic              scl_q, sda_q;
  logic              scl_s, sda_s;
  logic              scl_rise, scl_fall;
  logic              start_det, stop_det;
  logic              sda_oe;

  logic [7:0]        shreg;
  logic [3:0]        bit_cnt;
  logic [1:0]        byte_idx;
  logic [23:0]       word_buf;
  logic [ADDR_W-1:0] word_cnt;
  logic              nack_pend;

  logic [7:0]        byte_now;
  logic              addr_match;
  logic              byte_done;
  logic              word_done;
  logic              opcode_ok;
  logic              word_fail;

  logic              imem_we_r;
  logic [ADDR_W-1:0] imem_addr_r;
  logic [31:0]       imem_wdata_r;

  // Sync flops reset to the idle-bus level so a reset never fabricates a START/STOP.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], bus.scl_i};
      sda_sync <= {sda_sync[0], bus.sda_i};
      scl_q    <= scl_sync[1];
      sda_q    <= sda_sync[1];
    end
  end

  assign scl_s     = scl_sync[1];
  assign sda_s     = sda_sync[1];
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  // Our own ACK pulls SDA, so SDA edges are ignored while we drive it.
  assign start_det = scl_s & scl_q & sda_q & ~sda_s & ~sda_oe;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s & ~sda_oe;

  assign byte_now   = {shreg[6:0], sda_s};
  assign addr_match = (shreg[7:1] == DEV_ADDR) && !shreg[0];
  assign byte_done  = (state == DATA) && scl_rise && (bit_cnt == 4'd7);
  assign word_done  = byte_done && (byte_idx == 2'd3);
  assign word_fail  = word_done && !opcode_ok;

`ifdef I2C_LOADER_OPCODE_CHECK_EN
  always_comb begin
    opcode_ok = 1'b0;
    case (word_buf[6:0])
      7'b0110011, 7'b0010011, 7'b0000011,
      7'b0100011, 7'b1100011, 7'b1101111,
      7'b1100111, 7'b0110111, 7'b0010111: opcode_ok = 1'b1;
      default:                            opcode_ok = 1'b0;
    endcase
  end

  logic err_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (word_fail) begin
      err_r <= 1'b1;
    end
  end

  assign err = err_r;
`else
  assign opcode_ok = 1'b1;
  assign err       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // START and STOP override every state, including the ignore state.
  always_comb begin
    state_nxt = state;
    if (start_det) begin
      state_nxt = ADDR;
    end else if (stop_det) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:     state_nxt = IDLE;
        ADDR:     if (scl_fall && bit_cnt == 4'd8) state_nxt = addr_match ? ADDR_ACK : IGNORE;
        ADDR_ACK: if (scl_fall) state_nxt = DATA;
        DATA:     if (scl_fall && bit_cnt == 4'd8) state_nxt = nack_pend ? IGNORE : DATA_ACK;
        DATA_ACK: if (scl_fall) state_nxt = DATA;
        IGNORE:   state_nxt = IGNORE;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    sda_oe = 1'b0;
    if (state == ADDR_ACK || state == DATA_ACK) begin
      sda_oe = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg        <= 8'd0;
      bit_cnt      <= 4'd0;
      byte_idx     <= 2'd0;
      word_buf     <= 24'd0;
      word_cnt     <= '0;
      nack_pend    <= 1'b0;
      busy         <= 1'b0;
      load_done    <= 1'b0;
      imem_we_r    <= 1'b0;
      imem_addr_r  <= '0;
      imem_wdata_r <= 32'd0;
    end else begin
      imem_we_r <= 1'b0;
      load_done <= 1'b0;

      if ((state == ADDR || state == DATA) && scl_rise && bit_cnt != 4'd8) begin
        shreg   <= byte_now;
        bit_cnt <= bit_cnt + 4'd1;
      end

      if (state != DATA && state_nxt == DATA) begin
        bit_cnt <= 4'd0;
      end

      if (state == ADDR && state_nxt == ADDR_ACK) begin
        busy     <= 1'b1;
        byte_idx <= 2'd0;
      end

      // Bytes 0..2 wait in word_buf; byte 3 completes the word in place.
      if (byte_done) begin
        if (byte_idx == 2'd3) begin
          byte_idx <= 2'd0;
          if (opcode_ok) begin
            imem_we_r    <= 1'b1;
            imem_addr_r  <= word_cnt;
            imem_wdata_r <= {byte_now, word_buf};
            word_cnt     <= word_cnt + ADDR_W'(1);
          end
        end else begin
          byte_idx <= byte_idx + 2'd1;
          case (byte_idx)
            2'd0:    word_buf[7:0]   <= byte_now;
            2'd1:    word_buf[15:8]  <= byte_now;
            default: word_buf[23:16] <= byte_now;
          endcase
        end
      end

      if (word_fail) begin
        nack_pend <= 1'b1;
      end

      if (start_det) begin
        bit_cnt   <= 4'd0;
        byte_idx  <= 2'd0;
        nack_pend <= 1'b0;
      end else if (stop_det) begin
        bit_cnt   <= 4'd0;
        byte_idx  <= 2'd0;
        nack_pend <= 1'b0;
        busy      <= 1'b0;
        load_done <= busy;
      end
    end
  end

  assign bus.sda_oe     = sda_oe;
  assign bus.imem_we    = imem_we_r;
  assign bus.imem_addr  = imem_addr_r;
  assign bus.imem_wdata = imem_wdata_r;

endmodule

// File: doc/i2c_instr_loader.md
# i2c_instr_loader

I2C target that receives RISC-V instruction words from an external I2C controller and writes them into instruction memory. It sits between the board-level I2C pins and the instruction-memory write port, and produces the instruction stream that the core's control unit later decodes. Bytes arrive little-endian; each group of four becomes one 32-bit write at an auto-incrementing word address.

## Interface
- `DEV_ADDR`, default 7'h42: 7-bit I2C target address.
- `ADDR_W`, default 8: instruction-memory word-address width.
- `clk` input 1: system clock, at least 8x the SCL frequency.
- `rst` input 1: synchronous, active-high reset.
- `scl_i` input 1: raw SCL pin level, asynchronous.
- `sda_i` input 1: raw SDA pin level, asynchronous.
- `sda_oe` output 1: 1 pulls SDA low (open-drain ACK); 0 releases it.
- `imem_we` output 1: one-cycle write strobe.
- `imem_addr` output ADDR_W: word address of the write.
- `imem_wdata` output 32: assembled instruction word.
- `busy` output 1: high from an address-matched START until STOP.
- `load_done` output 1: one-cycle pulse on STOP after a matched write transaction.
- `err` output 1: sticky illegal-opcode flag; cleared only by `rst`.

## Operation
- `scl_i` and `sda_i` each pass through a 2-flop synchronizer, then a 1-flop edge detector.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high.
- FSM states: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
- IDLE → ADDR on START.
- ADDR: shift 8 bits MSB-first on SCL rising edges.
  - If bits[7:1]==DEV_ADDR and R/W==0, go to ADDR_ACK.
  - Otherwise go to IGNORE with SDA released (NACK).
- ADDR_ACK: drive the ACK, then go to DATA. Byte index resets to 0 and `busy` goes to 1.
- DATA: shift 8 bits. Byte k (0..3) lands in word bits [8k+7:8k]. Then go to DATA_ACK.
- On the 4th byte, the word is complete:
  - `imem_we` pulses with `imem_addr` = word counter.
  - The word counter increments, wrapping from 2^ADDR_W−1 to 0.
  - The byte index returns to 0.
- DATA_ACK → DATA.
- IGNORE: SDA is never driven. Leaves only on START (→ ADDR) or STOP (→ IDLE).
- START seen in any state (repeated START) → ADDR. Partial word bytes are discarded; the word counter is kept.
- STOP seen in any state → IDLE.
  - Partial word bytes are discarded; `busy` goes to 0.
  - `load_done` pulses if the transaction was matched.
- The word counter resets to 0 only on `rst`. Consecutive transactions append.
- `rst` mid-transfer: the FSM goes to IDLE, all outputs and counters clear, and SDA is released immediately. The next valid START is honored.

## Timing
- Reset values: `sda_oe`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `busy`=0, `load_done`=0, `err`=0. The FSM is in IDLE.
- A pin change is acted on 3 `clk` cycles after it occurs (2 sync flops + 1 edge-detect flop).
- ACK: `sda_oe` rises in the cycle after the detected SCL falling edge that ends bit 8. It falls in the cycle after the next detected SCL falling edge (end of the 9th clock).
- `imem_we` asserts 1 cycle after the detected SCL rising edge that samples bit 8 of the 4th byte.
  - `imem_addr` and `imem_wdata` are valid in the same cycle and hold until the next write.
- `load_done` asserts 1 cycle after STOP detection.
- SDA edges are not interpreted as START/STOP while `sda_oe`=1.

## Configuration
- `I2C_LOADER_OPCODE_CHECK_EN` defined:
  - Each completed word's bits[6:0] are checked against 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111.
  - On an illegal opcode: no `imem_we`, the counter does not increment, `err` is set, and the 4th byte is NACKed.
  - The FSM then goes to IGNORE until START/STOP.
- Undefined: every completed word is written and acked; `err` is tied to 0.

## Test plan
- Reset, then START, 0x84, bytes 33 05 00 00, STOP → one `imem_we` with addr 0, data 0x00000533. All 5 bytes acked. `load_done` pulses once.
- ADDR_W=2 with five words written in one transaction → writes at addresses 0,1,2,3,0 (wrap). `busy` stays high throughout.
- START, 0x86 (wrong address) or 0x85 (read) → `sda_oe` never asserts, no writes, `busy` stays 0, no `load_done` at STOP.
- START, 0x84, bytes 13 00, STOP, then START, 0x84, bytes 93 00 10 00, STOP → a single write of 0x00100093 at addr 0.
- `rst` asserted during the ACK of byte 2 → `sda_oe` is 0 on the next cycle, no write occurs, and a subsequent full word lands at addr 0.
- With `I2C_LOADER_OPCODE_CHECK_EN`, send word 0xFFFFFFFF → 4th byte NACKed, no write, `err`=1. A following valid transaction writes to addr 0.
